// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operation codes and the latency-lookup result type
// used by the issue sequencer.
package fpu_pkg;

    localparam int FPU_OP_W = 6;

    localparam logic [FPU_OP_W-1:0] FPU_OP_FADD     = 6'd0;
    localparam logic [FPU_OP_W-1:0] FPU_OP_FSUB     = 6'd1;
    localparam logic [FPU_OP_W-1:0] FPU_OP_FCVT_S_W = 6'd4;
    localparam logic [FPU_OP_W-1:0] FPU_OP_FEQ      = 6'd16;

    // Packs as {legal, lat[3:0]}.
    typedef struct packed {
        logic       legal;
        logic [3:0] lat;
    } fpu_lat_t;

endpackage

// File: rtl/fpu_lat_lut.sv
// Combinational op-code decoder: reports whether the fpu implements an op
// and how many cycles its result takes to settle.
module fpu_lat_lut
    import fpu_pkg::*;
#(
    parameter int ADD_LAT  = 2,
    parameter int MISC_LAT = 1
) (
    input  logic [FPU_OP_W-1:0] op,
    output fpu_lat_t            info
);

    always_comb begin
        // NOTE: assign every combinational output a default first so no path leaves it unassigned (no latch).
        info = '{legal: 1'b0, lat: 4'd1};
        if (op == FPU_OP_FADD || op == FPU_OP_FSUB) begin
            info = '{legal: 1'b1, lat: 4'(ADD_LAT)};
        end else if (op >= FPU_OP_FCVT_S_W && op <= FPU_OP_FEQ) begin
            info = '{legal: 1'b1, lat: 4'(MISC_LAT)};
        end
    end

endmodule

// File: rtl/fpu_issue_seq.sv
// Single-outstanding issue sequencer in front of the fpu datapath: holds the
// op on the fpu inputs for its fixed latency and returns the captured result.
module fpu_issue_seq
    import fpu_pkg::*;
#(
    parameter int FLEN     = 32,
    parameter int TAG_W    = 5,
    parameter int ADD_LAT  = 2,
    parameter int MISC_LAT = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [FPU_OP_W-1:0] req_op,
    input  logic [FLEN-1:0]     req_rs1,
    input  logic [FLEN-1:0]     req_rs2,
    input  logic [31:0]         req_fcsr,
    input  logic [TAG_W-1:0]    req_tag,
    output logic [FPU_OP_W-1:0] fpu_operation,
    output logic [FLEN-1:0]     fpu_rs1,
    output logic [FLEN-1:0]     fpu_rs2,
    output logic [31:0]         fpu_fcsr,
    input  logic [FLEN-1:0]     fpu_result,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [FLEN-1:0]     resp_data,
    output logic [TAG_W-1:0]    resp_tag,
    output logic                resp_illegal,
    output logic                busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic [TAG_W-1:0] op_tag;
    logic             op_illegal;
    fpu_lat_t         lut;
    logic             accept;
    logic             finish;

    fpu_lat_lut #(
        .ADD_LAT  (ADD_LAT),
        .MISC_LAT (MISC_LAT)
    ) u_lat_lut (
        .op   (req_op),
        .info (lut)
    );

    // A DONE slot can hand off straight to the next op when the response drains.
    assign req_ready  = ~flush & ((state == ST_IDLE) | ((state == ST_DONE) & resp_ready));
    assign accept     = req_valid & req_ready;
    assign finish     = ~flush & (state == ST_EXEC) & (cnt <= 4'd1);
    assign resp_valid = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_EXEC;
                        cnt   <= lut.lat;
                    end
                end
                ST_EXEC: begin
                    if (cnt <= 4'd1) begin
                        state <= ST_DONE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        state <= accept ? ST_EXEC : ST_IDLE;
                        cnt   <= accept ? lut.lat : 4'd0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // fpu inputs change only on accept, so they survive a flush untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fpu_operation <= '0;
            fpu_rs1       <= '0;
            fpu_rs2       <= '0;
            fpu_fcsr      <= '0;
            op_tag        <= '0;
            op_illegal    <= 1'b0;
        end else if (accept) begin
            fpu_operation <= req_op;
            fpu_rs1       <= req_rs1;
            fpu_rs2       <= req_rs2;
            fpu_fcsr      <= req_fcsr;
            op_tag        <= req_tag;
            op_illegal    <= ~lut.legal;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_data    <= '0;
            resp_tag     <= '0;
            resp_illegal <= 1'b0;
        end else if (finish) begin
            resp_data    <= op_illegal ? '0 : fpu_result;
            resp_tag     <= op_tag;
            resp_illegal <= op_illegal;
        end
    end

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed bench for fpu_issue_seq with a stub fpu that returns known results
// for the vectors used here.
module tb_fpu_issue_seq;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [31:0] req_fcsr;
    logic [4:0]  req_tag;
    logic [5:0]  fpu_operation;
    logic [31:0] fpu_rs1;
    logic [31:0] fpu_rs2;
    logic [31:0] fpu_fcsr;
    logic [31:0] fpu_result;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        resp_illegal;
    logic        busy;

    int vectors;
    int miscompares;

    fpu_issue_seq #(
        .FLEN     (32),
        .TAG_W    (5),
        .ADD_LAT  (2),
        .MISC_LAT (1)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_fcsr      (req_fcsr),
        .req_tag       (req_tag),
        .fpu_operation (fpu_operation),
        .fpu_rs1       (fpu_rs1),
        .fpu_rs2       (fpu_rs2),
        .fpu_fcsr      (fpu_fcsr),
        .fpu_result    (fpu_result),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_tag      (resp_tag),
        .resp_illegal  (resp_illegal),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub fpu: exact answers for the directed vectors, a^b otherwise.
    function automatic logic [31:0] fake_fpu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            6'd0:    return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a ^ b;
            6'd1:    return (a == 32'h40400000 && b == 32'h3F800000) ? 32'h40000000 : a ^ b;
            6'd12:   return {~b[31], a[30:0]};
            6'd16:   return {31'd0, a == b};
            default: return a ^ b;
        endcase
    endfunction

    always_comb fpu_result = fake_fpu(fpu_operation, fpu_rs1, fpu_rs2);

    task automatic drive_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_fcsr  = {27'd0, tag};
        req_tag   = tag;
        req_valid = 1'b1;
    endtask

    // Returns 1 ns after the accepting edge, or with ok=0 after a 20-cycle bound.
    task automatic do_accept(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] tag, output bit ok);
        drive_req(op, a, b, tag);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        bit ok;
        bit seen;
        resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = '0; req_rs1 = '0; req_rs2 = '0; req_fcsr = '0; req_tag = '0;
        #3;
        vectors++; if (req_ready !== 1'b1) begin $display("FAIL reset_req_ready got %b want 1", req_ready); miscompares++; end
        vectors++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin $display("FAIL reset_idle got valid=%b busy=%b want 0/0", resp_valid, busy); miscompares++; end
        vectors++; if (fpu_operation !== 6'd0 || resp_data !== 32'd0) begin $display("FAIL reset_regs got op=%h data=%h want 0/0", fpu_operation, resp_data); miscompares++; end
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        // Reset asserted between edges while an fadd is executing.
        resp_ready = 1'b1;
        do_accept(6'd0, 32'h3F800000, 32'h40000000, 5'd4, ok);
        vectors++; if (ok !== 1'b1 || busy !== 1'b1) begin $display("FAIL midexec_accept got ok=%b busy=%b want 1/1", ok, busy); miscompares++; end
        #2 resetn = 1'b0;
        #1;
        vectors++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin $display("FAIL midexec_reset got valid=%b busy=%b ready=%b want 0/0/1", resp_valid, busy, req_ready); miscompares++; end
        vectors++; if (fpu_rs1 !== 32'd0 || fpu_rs2 !== 32'd0 || fpu_fcsr !== 32'd0) begin $display("FAIL midexec_fpu_regs got %h %h %h want 0", fpu_rs1, fpu_rs2, fpu_fcsr); miscompares++; end
        @(negedge clk) resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen |= resp_valid;
        end
        vectors++; if (seen !== 1'b0) begin $display("FAIL midexec_no_resp got resp_valid seen=%b want 0", seen); miscompares++; end
    endtask

    task automatic test_add();
        bit ok;
        int cyc;
        resp_ready = 1'b1;
        do_accept(6'd0, 32'h3F800000, 32'h40000000, 5'd5, ok);
        vectors++; if (fpu_fcsr !== 32'd5 || fpu_rs2 !== 32'h40000000) begin $display("FAIL add_fpu_regs got fcsr=%h rs2=%h want 5/40000000", fpu_fcsr, fpu_rs2); miscompares++; end
        wait_resp(cyc);
        vectors++; if (ok !== 1'b1 || cyc !== 2) begin $display("FAIL add_latency got ok=%b cyc=%0d want 1/2", ok, cyc); miscompares++; end
        vectors++; if (resp_data !== 32'h40400000 || resp_tag !== 5'd5 || resp_illegal !== 1'b0) begin $display("FAIL add_resp got %h tag %0d ill %b want 40400000 tag 5 ill 0", resp_data, resp_tag, resp_illegal); miscompares++; end
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin $display("FAIL add_drain got busy=%b valid=%b want 0/0", busy, resp_valid); miscompares++; end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        resp_ready = 1'b1;
        do_accept(6'd1, 32'h40400000, 32'h3F800000, 5'd1, ok);
        wait_resp(cyc);
        vectors++; if (ok !== 1'b1 || cyc !== 2) begin $display("FAIL b2b_sub_latency got ok=%b cyc=%0d want 1/2", ok, cyc); miscompares++; end
        drive_req(6'd12, 32'h3F800000, 32'h3F800000, 5'd2);
        #1;
        vectors++; if (req_ready !== 1'b1) begin $display("FAIL b2b_ready_in_done got %b want 1", req_ready); miscompares++; end
        vectors++; if (resp_data !== 32'h40000000 || resp_tag !== 5'd1) begin $display("FAIL b2b_resp1 got %h tag %0d want 40000000 tag 1", resp_data, resp_tag); miscompares++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        vectors++; if (busy !== 1'b1 || resp_valid !== 1'b0 || fpu_operation !== 6'd12) begin $display("FAIL b2b_no_bubble got busy=%b valid=%b op=%0d want 1/0/12", busy, resp_valid, fpu_operation); miscompares++; end
        wait_resp(cyc);
        vectors++; if (cyc !== 1 || resp_data !== 32'hBF800000 || resp_tag !== 5'd2) begin $display("FAIL b2b_resp2 got cyc=%0d %h tag %0d want 1 BF800000 tag 2", cyc, resp_data, resp_tag); miscompares++; end
        vectors++; if (req_ready !== 1'b1) begin $display("FAIL b2b_ready_in_done2 got %b want 1", req_ready); miscompares++; end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit ok;
        int cyc;
        resp_ready = 1'b0;
        do_accept(6'd16, 32'h41200000, 32'h41200000, 5'd7, ok);
        wait_resp(cyc);
        vectors++; if (ok !== 1'b1 || cyc !== 1) begin $display("FAIL bp_latency got ok=%b cyc=%0d want 1/1", ok, cyc); miscompares++; end
        drive_req(6'd4, 32'h0, 32'h0, 5'd8);
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (resp_valid !== 1'b1 || resp_data !== 32'h1 || resp_tag !== 5'd7 || req_ready !== 1'b0) begin
                $display("FAIL bp_hold[%0d] got valid=%b data=%h tag=%0d ready=%b want 1/00000001/7/0", i, resp_valid, resp_data, resp_tag, req_ready); miscompares++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin $display("FAIL bp_release got busy=%b valid=%b want 0/0", busy, resp_valid); miscompares++; end
    endtask

    task automatic test_illegal();
        bit ok;
        int cyc;
        resp_ready = 1'b1;
        do_accept(6'd2, 32'h1, 32'h2, 5'd3, ok);
        wait_resp(cyc);
        vectors++; if (ok !== 1'b1 || cyc !== 1 || resp_illegal !== 1'b1 || resp_data !== 32'd0 || resp_tag !== 5'd3) begin
            $display("FAIL illegal_op2 got cyc=%0d ill=%b data=%h tag=%0d want 1/1/0/3", cyc, resp_illegal, resp_data, resp_tag); miscompares++;
        end
        @(posedge clk); #1;
        do_accept(6'd17, 32'h5, 32'h6, 5'd6, ok);
        wait_resp(cyc);
        vectors++; if (cyc !== 1 || resp_illegal !== 1'b1 || resp_data !== 32'd0) begin $display("FAIL illegal_op17 got cyc=%0d ill=%b data=%h want 1/1/0", cyc, resp_illegal, resp_data); miscompares++; end
        @(posedge clk); #1;
        do_accept(6'd4, 32'h12345678, 32'h0F0F0F0F, 5'd9, ok);
        wait_resp(cyc);
        vectors++; if (cyc !== 1 || resp_illegal !== 1'b0 || resp_data !== 32'h1D3B5977 || resp_tag !== 5'd9) begin
            $display("FAIL legal_after_illegal got cyc=%0d ill=%b data=%h tag=%0d want 1/0/1D3B5977/9", cyc, resp_illegal, resp_data, resp_tag); miscompares++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        bit ok;
        bit seen;
        int cyc;
        resp_ready = 1'b1;
        do_accept(6'd0, 32'h3F800000, 32'h40000000, 5'd10, ok);
        flush = 1'b1;
        drive_req(6'd4, 32'h12345678, 32'h0, 5'd11);
        #1;
        vectors++; if (req_ready !== 1'b0) begin $display("FAIL flush_blocks_ready got %b want 0", req_ready); miscompares++; end
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = 1'b0;
        vectors++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin $display("FAIL flush_idle got busy=%b valid=%b want 0/0", busy, resp_valid); miscompares++; end
        vectors++; if (fpu_rs1 !== 32'h3F800000 || fpu_fcsr !== 32'd10) begin $display("FAIL flush_retain got rs1=%h fcsr=%h want 3F800000/a", fpu_rs1, fpu_fcsr); miscompares++; end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            seen |= resp_valid;
        end
        vectors++; if (seen !== 1'b0) begin $display("FAIL flush_no_resp got seen=%b want 0", seen); miscompares++; end
        do_accept(6'd0, 32'h3F800000, 32'h40000000, 5'd12, ok);
        wait_resp(cyc);
        vectors++; if (ok !== 1'b1 || cyc !== 2 || resp_data !== 32'h40400000 || resp_tag !== 5'd12) begin
            $display("FAIL flush_reissue got ok=%b cyc=%0d data=%h tag=%0d want 1/2/40400000/12", ok, cyc, resp_data, resp_tag); miscompares++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
